// File: rtl/led_sampler_pkg.sv
// Shared FSM state type, pixel-bus widths and the luma/threshold compare for the LED bit sampler.
package led_sampler_pkg;
    localparam int PIXEL_W  = 8;
    localparam int THRESH_W = 8;
    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

    function automatic logic at_or_above(input logic [PIXEL_W-1:0]  luma,
                                         input logic [THRESH_W-1:0] thresh);
        return luma >= thresh;
    endfunction
endpackage

// File: rtl/sampler_pipe.sv
// Two-stage sampler pipeline: block coordinates and luma compare, then the linear accumulator address.
module sampler_pipe
    import led_sampler_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int DS       = 3,
    parameter int ADDR_W   = 14
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                sample_en,
    input  logic [HCOUNT_W-1:0] hcount,
    input  logic [VCOUNT_W-1:0] vcount,
    input  logic [PIXEL_W-1:0]  pixel,
    input  logic [THRESH_W-1:0] thresh,
    output logic                in_flight,
    output logic                vld_p1,
    output logic [ADDR_W-1:0]   addr_p1,
    output logic                summand_p1
);
    localparam int BLOCKS_PER_ROW = H_ACTIVE >> DS;

    logic              vld_p0;
    logic [ADDR_W-1:0] row_p0;
    logic [ADDR_W-1:0] col_p0;
    logic              summand_p0;

    // stage 0: block row/column and threshold decision
    always_ff @(posedge clk_in) begin
        if (rst_in) vld_p0 <= 1'b0;
        else        vld_p0 <= sample_en;
        row_p0     <= ADDR_W'(vcount >> DS);
        col_p0     <= ADDR_W'(hcount >> DS);
        summand_p0 <= at_or_above(pixel, thresh);
    end

    // stage 1: raster-order address; outputs are cleared by reset so nothing in flight escapes
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_p1     <= 1'b0;
            addr_p1    <= '0;
            summand_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                addr_p1    <= row_p0 * ADDR_W'(BLOCKS_PER_ROW) + col_p0;
                summand_p1 <= summand_p0;
            end
        end
    end

    assign in_flight = vld_p0 | vld_p1;
endmodule

// File: rtl/led_bit_sampler.sv
// LED bit sampler: captures NUM_FRAMES frames, one thresholded luma bit per 2^DS x 2^DS block.
// Define LED_SAMPLER_ONES_COUNT_EN to add ones_count_out (bright samples in the last completed frame).
module led_bit_sampler
    import led_sampler_pkg::*;
#(
    parameter  int H_ACTIVE   = 1280,
    parameter  int V_ACTIVE   = 720,
    parameter  int DS         = 3,
    parameter  int NUM_FRAMES = 16,
    localparam int DEPTH      = (H_ACTIVE >> DS) * (V_ACTIVE >> DS),
    localparam int ADDR_W     = $clog2(DEPTH),
    localparam int FC_W       = $clog2(NUM_FRAMES + 1)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                start_in,
    input  logic [THRESH_W-1:0] threshold_in,
    input  logic                pixel_valid_in,
    input  logic [HCOUNT_W-1:0] hcount_in,
    input  logic [VCOUNT_W-1:0] vcount_in,
    input  logic [PIXEL_W-1:0]  pixel_in,
    output logic [ADDR_W-1:0]   addr_out,
    output logic                summand_out,
    output logic                request_valid_out,
    output logic [FC_W-1:0]     frame_count_out,
    output logic                busy_out,
    output logic                done_out
`ifdef LED_SAMPLER_ONES_COUNT_EN
    ,
    output logic [ADDR_W:0]     ones_count_out
`endif
);
    localparam logic [HCOUNT_W-1:0] H_LAST  = HCOUNT_W'(H_ACTIVE - 1);
    localparam logic [VCOUNT_W-1:0] V_LAST  = VCOUNT_W'(V_ACTIVE - 1);
    localparam logic [HCOUNT_W-1:0] H_MASK  = HCOUNT_W'((1 << DS) - 1);
    localparam logic [VCOUNT_W-1:0] V_MASK  = VCOUNT_W'((1 << DS) - 1);
    localparam logic [FC_W-1:0]     FC_LAST = FC_W'(NUM_FRAMES - 1);

    state_t              state;
    logic [THRESH_W-1:0] thresh_q;
    logic [THRESH_W-1:0] thresh_sel;
    logic                sof;
    logic                eof;
    logic                on_grid;
    logic                sample_en;
    logic                in_flight;

    assign sof     = pixel_valid_in && hcount_in == '0 && vcount_in == '0;
    assign eof     = pixel_valid_in && hcount_in == H_LAST && vcount_in == V_LAST;
    assign on_grid = pixel_valid_in && hcount_in <= H_LAST && vcount_in <= V_LAST
                     && (hcount_in & H_MASK) == '0 && (vcount_in & V_MASK) == '0;

    // The SOF pixel opens the first frame, so it is sampled with the live threshold on capture entry.
    assign sample_en  = on_grid && (state == CAPTURE || (state == WAIT_SOF && sof));
    assign thresh_sel = (state == CAPTURE) ? thresh_q : threshold_in;

    always_ff @(posedge clk_in) begin
        done_out <= 1'b0;
        if (rst_in) begin
            state           <= IDLE;
            busy_out        <= 1'b0;
            frame_count_out <= '0;
        end else begin
            case (state)
                IDLE: if (start_in) begin
                    state    <= WAIT_SOF;
                    busy_out <= 1'b1;
                end
                WAIT_SOF: if (sof) begin
                    state           <= CAPTURE;
                    frame_count_out <= '0;
                    thresh_q        <= threshold_in;
                end
                CAPTURE: if (eof) begin
                    frame_count_out <= frame_count_out + FC_W'(1);
                    if (frame_count_out == FC_LAST) state <= DONE;
                end
                DONE: if (!in_flight) begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                    done_out <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sampler_pipe #(
        .H_ACTIVE (H_ACTIVE),
        .DS       (DS),
        .ADDR_W   (ADDR_W)
    ) u_pipe (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .sample_en  (sample_en),
        .hcount     (hcount_in),
        .vcount     (vcount_in),
        .pixel      (pixel_in),
        .thresh     (thresh_sel),
        .in_flight  (in_flight),
        .vld_p1     (request_valid_out),
        .addr_p1    (addr_out),
        .summand_p1 (summand_out)
    );

`ifdef LED_SAMPLER_ONES_COUNT_EN
    logic [ADDR_W:0] ones_run;
    logic [ADDR_W:0] ones_inc;

    // Counted at sample time so a hit on the EOF pixel itself still lands in its own frame.
    assign ones_inc = {{ADDR_W{1'b0}}, sample_en && at_or_above(pixel_in, thresh_sel)};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ones_run       <= '0;
            ones_count_out <= '0;
        end else if (state == CAPTURE && eof) begin
            ones_count_out <= ones_run + ones_inc;
            ones_run       <= '0;
        end else if (sof && (state == WAIT_SOF || state == CAPTURE)) begin
            ones_run <= ones_inc;
        end else begin
            ones_run <= ones_run + ones_inc;
        end
    end
`endif
endmodule
